bike_reg_bank_arb: RTL and testbench

BIKE_REG_BANK_ARB -- requirements
Module: bike_reg_bank_arb

---
 rtl/bike_pkg.sv | 22 ++
 rtl/bike_rr_arb2.sv | 33 +++
 rtl/bike_reg_bank_arb.sv | 172 +++++++++++++++++
 tb/tb_bike_reg_bank_arb.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bike_pkg.sv
// Shared types and helpers for the BIKE register-bank write arbiter.
// Holds the controller state enum, the bank word width and a one-hot decoder.

package bike_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned MAX_SIZE = 64;

  typedef enum logic {
    IDLE,
    CLEAR
  } bike_state_e;

  // Index is 6 bits wide so every legal bank size (up to 64) fits.
  function automatic logic [MAX_SIZE-1:0] onehot(input logic [5:0] idx);
    logic [MAX_SIZE-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/bike_rr_arb2.sv
// Two-port round-robin arbiter: the port not granted last wins a tie.
// The last-grant register advances only when the grant is actually consumed (en).

module bike_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic last_b_q, last_b_d;

  always_comb begin
    if (req == 2'b11) begin
      gnt = last_b_q ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

  assign last_b_d = (en && (gnt != 2'b00)) ? gnt[1] : last_b_q;

  // Reset as if B won last, so A has priority on the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_b_q <= 1'b1;
    end else begin
      last_b_q <= last_b_d;
    end
  end

endmodule

// File: rtl/bike_reg_bank_arb.sv
// Arbitrates host-load (A) and write-back (B) writes into a SIZE-entry register bank.
// Optional clear sweep is compiled in with BIKE_REG_BANK_ARB_CLEAR_EN.

module bike_reg_bank_arb
  import bike_pkg::*;
#(
  parameter int unsigned SIZE = 8,
  parameter int unsigned AW   = $clog2(SIZE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [AW-1:0]     a_addr,
  input  logic [WORD_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [AW-1:0]     b_addr,
  input  logic [WORD_W-1:0] b_data,
  input  logic              clr_start,
  output logic              busy,
  output logic [SIZE-1:0]   bank_en,
  output logic [WORD_W-1:0] bank_din,
  output logic [SIZE-1:0]   written,
  output logic              all_written,
  output logic              addr_err
);

  bike_state_e state_q, state_d;

  logic [1:0]        gnt;
  logic              accept_ok;
  logic              clr_go;
  logic              xfer;
  logic [AW-1:0]     sel_addr;
  logic [WORD_W-1:0] sel_data;
  logic              sel_in_range;
  logic [SIZE-1:0]   sel_dec;

  logic [SIZE-1:0]   wr_en_q, wr_en_d;
  logic [WORD_W-1:0] wr_din_q, wr_din_d;
  logic [SIZE-1:0]   written_q, written_d;
  logic              addr_err_q, addr_err_d;

`ifdef BIKE_REG_BANK_ARB_CLEAR_EN
  logic [AW-1:0] cnt_q, cnt_d;

  assign clr_go = (state_q == IDLE) && clr_start;
`else
  logic unused_clr_start;

  assign unused_clr_start = clr_start;
  assign clr_go           = 1'b0;
`endif

  // A clear request in IDLE blocks any transfer that same cycle.
  assign accept_ok = !reset && (state_q == IDLE) && !clr_go;
  assign xfer      = accept_ok && (gnt != 2'b00);

  bike_rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({b_valid, a_valid}),
    .en    (accept_ok),
    .gnt   (gnt)
  );

  assign sel_addr     = gnt[1] ? b_addr : a_addr;
  assign sel_data     = gnt[1] ? b_data : a_data;
  assign sel_in_range = 32'(sel_addr) < SIZE;
  assign sel_dec      = SIZE'(onehot(6'(sel_addr)));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
`ifdef BIKE_REG_BANK_ARB_CLEAR_EN
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == AW'(SIZE - 1)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
`else
    state_d = IDLE;
`endif
  end

  // Output logic
  always_comb begin
    busy     = 1'b0;
    bank_en  = wr_en_q;
    bank_din = wr_din_q;
    a_ready  = accept_ok && gnt[0];
    b_ready  = accept_ok && gnt[1];
`ifdef BIKE_REG_BANK_ARB_CLEAR_EN
    if (state_q == CLEAR) begin
      busy     = 1'b1;
      bank_en  = SIZE'(onehot(6'(cnt_q)));
      bank_din = '0;
    end
`endif
  end

`ifdef BIKE_REG_BANK_ARB_CLEAR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // Write path: accepted word appears on the bank one cycle later.
  always_comb begin
    wr_en_d    = '0;
    wr_din_d   = '0;
    written_d  = written_q;
    addr_err_d = addr_err_q;
    if (clr_go) begin
      written_d  = '0;
      addr_err_d = 1'b0;
    end else if (xfer) begin
      if (sel_in_range) begin
        wr_en_d   = sel_dec;
        wr_din_d  = sel_data;
        written_d = written_q | sel_dec;
      end else begin
        addr_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en_q    <= '0;
      wr_din_q   <= '0;
      written_q  <= '0;
      addr_err_q <= 1'b0;
    end else begin
      wr_en_q    <= wr_en_d;
      wr_din_q   <= wr_din_d;
      written_q  <= written_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign written     = written_q;
  assign all_written = &written_q;
  assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_bike_reg_bank_arb.sv
// Bench for bike_reg_bank_arb: a transaction-level model checked every cycle,
// plus directed vectors with literal expectations on an 8-entry and a 10-entry bank.

module tb_bike_reg_bank_arb;

  localparam int SIZE = 8;
`ifdef BIKE_REG_BANK_ARB_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0, clr_start = 1'b0;
  logic [2:0]  a_addr = '0, b_addr = '0;
  logic [31:0] a_data = '0, b_data = '0;
  logic        a_ready, b_ready, busy, all_written, addr_err;
  logic [7:0]  bank_en, written;
  logic [31:0] bank_din;

  // Second instance with a 10-entry bank exercises out-of-range addresses.
  logic        b10_valid = 1'b0;
  logic [3:0]  b10_addr = '0;
  logic [31:0] b10_data = '0;
  logic        a10_ready, b10_ready, busy10, all10, err10;
  logic [9:0]  en10, written10;
  logic [31:0] din10;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bike_reg_bank_arb #(.SIZE(SIZE)) dut (
    .clk        (clk),
    .reset      (reset),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_addr     (a_addr),
    .a_data     (a_data),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_addr     (b_addr),
    .b_data     (b_data),
    .clr_start  (clr_start),
    .busy       (busy),
    .bank_en    (bank_en),
    .bank_din   (bank_din),
    .written    (written),
    .all_written(all_written),
    .addr_err   (addr_err)
  );

  bike_reg_bank_arb #(.SIZE(10)) dut10 (
    .clk        (clk),
    .reset      (reset),
    .a_valid    (1'b0),
    .a_ready    (a10_ready),
    .a_addr     (4'd0),
    .a_data     (32'd0),
    .b_valid    (b10_valid),
    .b_ready    (b10_ready),
    .b_addr     (b10_addr),
    .b_data     (b10_data),
    .clr_start  (1'b0),
    .busy       (busy10),
    .bank_en    (en10),
    .bank_din   (din10),
    .written    (written10),
    .all_written(all10),
    .addr_err   (err10)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- model ----------------
  bit         m_clear  = 1'b0;
  int         m_idx    = 0;
  bit         m_last_b = 1'b1;   // "B won last" => A wins the first tie
  logic [7:0] m_written = '0;
  bit         m_err    = 1'b0;
  logic [7:0] m_en     = '0;
  logic [31:0] m_din   = '0;

  // Which port may transfer right now, from the arbitration rules.
  function automatic logic [1:0] exp_ready();
    if (reset || m_clear || (CLEAR_EN && clr_start)) return 2'b00;
    if (a_valid && b_valid) return m_last_b ? 2'b01 : 2'b10;
    return {b_valid, a_valid};
  endfunction

  function automatic int grant_addr();
    return (exp_ready() == 2'b10) ? int'(b_addr) : int'(a_addr);
  endfunction

  function automatic logic [31:0] grant_data();
    return (exp_ready() == 2'b10) ? b_data : a_data;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_clear   <= 1'b0;
      m_idx     <= 0;
      m_last_b  <= 1'b1;
      m_written <= '0;
      m_err     <= 1'b0;
      m_en      <= '0;
      m_din     <= '0;
    end else begin
      m_en  <= '0;
      m_din <= '0;
      if (m_clear) begin
        if (m_idx == SIZE - 1) m_clear <= 1'b0;
        m_idx <= m_idx + 1;
      end else if (CLEAR_EN && clr_start) begin
        m_clear   <= 1'b1;
        m_idx     <= 0;
        m_written <= '0;
        m_err     <= 1'b0;
      end else if (exp_ready() != 2'b00) begin
        if (grant_addr() < SIZE) begin
          m_en      <= 8'(1) << grant_addr();
          m_din     <= grant_data();
          m_written <= m_written | (8'(1) << grant_addr());
        end else begin
          m_err <= 1'b1;
        end
        m_last_b <= (exp_ready() == 2'b10);
      end
    end
  end

  always @(negedge clk) begin
    chk("a_ready", a_ready, exp_ready() & {1'b0, a_valid});
    chk("b_ready", b_ready, (exp_ready() >> 1) & {1'b0, b_valid});
    chk("busy", busy, m_clear);
    chk("bank_en", bank_en, m_clear ? (8'(1) << m_idx) : m_en);
    if (bank_en != 8'd0) chk("bank_din", bank_din, m_clear ? 32'd0 : m_din);
    chk("written", written, m_written);
    chk("all_written", all_written, m_written == 8'hFF);
    chk("addr_err", addr_err, m_err);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    a_valid = 1'b1;
    a_addr  = 3'd3;
    tick();
    tick();
    chk("rst_a_ready", a_ready, 0);
    chk("rst_bank_en", bank_en, 0);
    chk("rst_written", written, 0);
    chk("rst_busy", busy, 0);
    a_valid = 1'b0;
    reset   = 1'b0;
    tick();

    // Single write, one-cycle latency
    a_valid = 1'b1; a_addr = 3'd3; a_data = 32'hDEADBEEF;
    #1 chk("solo_a_ready", a_ready, 1);
    tick();
    a_valid = 1'b0;
    chk("wr3_en", bank_en, 8'h08);
    chk("wr3_din", bank_din, 32'hDEADBEEF);
    chk("wr3_written", written, 8'h08);
    tick();
    chk("wr3_en_drop", bank_en, 8'h00);

    // Round robin from a fresh reset: A,B,A,B
    reset = 1'b1;
    tick();
    reset = 1'b0;
    a_valid = 1'b1; a_addr = 3'd1; a_data = 32'hA1A1A1A1;
    b_valid = 1'b1; b_addr = 3'd2; b_data = 32'hB2B2B2B2;
    for (int k = 0; k < 4; k++) begin
      #1 chk("rr_a_ready", a_ready, (k % 2) == 0);
      tick();
      chk("rr_bank_en", bank_en, (k % 2) ? 8'h04 : 8'h02);
      chk("rr_bank_din", bank_din, (k % 2) ? 32'hB2B2B2B2 : 32'hA1A1A1A1);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    tick();

    // B alone, then a tie must go to A
    b_valid = 1'b1; b_addr = 3'd6; b_data = 32'h00000066;
    #1 chk("solo_b_ready", b_ready, 1);
    tick();
    chk("b6_en", bank_en, 8'h40);
    a_valid = 1'b1; a_addr = 3'd5; a_data = 32'h00000055;
    #1 chk("tie_after_b", {b_ready, a_ready}, 2'b01);
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    chk("a5_en", bank_en, 8'h20);
    chk("written_1256", written, 8'h66);

    // Sweep all addresses; all_written rises with the last one
    for (int i = 0; i < SIZE; i++) begin
      a_valid = 1'b1; a_addr = 3'(i); a_data = 32'h11111111 * i;
      tick();
      chk("seq_en", bank_en, 8'(1) << i);
      chk("seq_all_written", all_written, i == SIZE - 1);
    end

    // Asynchronous reset mid-cycle clears everything at once
    #2 reset = 1'b1;
    #1;
    chk("async_rst_en", bank_en, 0);
    chk("async_rst_written", written, 0);
    chk("async_rst_all", all_written, 0);
    chk("async_rst_ready", a_ready, 0);
    a_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // 10-entry bank: 9 is in range, 12 and 15 are not
    b10_valid = 1'b1; b10_addr = 4'd9; b10_data = 32'h99999999;
    tick();
    chk("b10_9_en", en10, 10'h200);
    chk("b10_9_err", err10, 0);
    b10_addr = 4'd12;
    tick();
    chk("b10_12_en", en10, 10'h000);
    chk("b10_12_err", err10, 1);
    chk("b10_12_written", written10, 10'h200);
    b10_addr = 4'd4;
    tick();
    chk("b10_4_en", en10, 10'h010);
    chk("b10_err_sticky", err10, 1);
    b10_addr = 4'd15;
    tick();
    b10_valid = 1'b0;
    chk("b10_15_en", en10, 10'h000);
    chk("b10_15_written", written10, 10'h210);
    tick();

`ifdef BIKE_REG_BANK_ARB_CLEAR_EN
    // Clear beats a simultaneous request, then A goes through afterwards
    clr_start = 1'b1;
    a_valid = 1'b1; a_addr = 3'd3; a_data = 32'hCAFEF00D;
    #1 chk("clr_a_ready", a_ready, 0);
    tick();
    clr_start = 1'b0;
    for (int i = 0; i < SIZE; i++) begin
      chk("sweep_busy", busy, 1);
      chk("sweep_en", bank_en, 8'(1) << i);
      chk("sweep_din", bank_din, 0);
      chk("sweep_written", written, 0);
      chk("sweep_a_ready", a_ready, 0);
      tick();
    end
    chk("post_busy", busy, 0);
    chk("post_a_ready", a_ready, 1);
    tick();
    a_valid = 1'b0;
    chk("post_en", bank_en, 8'h08);
    chk("post_din", bank_din, 32'hCAFEF00D);

    // Reset during the third sweep cycle
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    tick();
    tick();
    chk("sweep3_en", bank_en, 8'h04);
    #2 reset = 1'b1;
    #1;
    chk("sweep_rst_busy", busy, 0);
    chk("sweep_rst_en", bank_en, 0);
    chk("sweep_rst_din", bank_din, 0);
    tick();
    reset = 1'b0;
    tick();
`else
    // Without the clear feature, clr_start has no effect
    clr_start = 1'b1;
    a_valid = 1'b1; a_addr = 3'd5; a_data = 32'h5A5A5A5A;
    #1;
    chk("noclr_busy", busy, 0);
    chk("noclr_a_ready", a_ready, 1);
    tick();
    clr_start = 1'b0;
    a_valid = 1'b0;
    chk("noclr_en", bank_en, 8'h20);
    chk("noclr_din", bank_din, 32'h5A5A5A5A);
    chk("noclr_busy_after", busy, 0);
    tick();
`endif

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
